// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: per-port L0 and shared L1 event vectors, plus perf-counter index layout.
// Latency: n/a (types and constants only). Backpressure: n/a.
package snitch_icache_pkg;

    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
        logic l0_stall;
    } icache_l0_events_t;

    typedef struct packed {
        logic l1_miss;
        logic l1_hit;
        logic l1_stall;
        logic l1_handler_stall;
    } icache_l1_events_t;

    localparam int unsigned L0_EVENT_COUNT = 5;
    localparam int unsigned L1_EVENT_COUNT = 4;

    typedef enum logic [0:0] {
        PERF_IDX_BASE_L0,
        PERF_IDX_BASE_L1
    } icache_perf_idx_base_e;

    // L0 counters are packed port-major from index 0; L1 counters follow all ports.
    function automatic int unsigned perf_idx_base(input int unsigned nr_fetch_ports,
                                                  input icache_perf_idx_base_e sel);
        return (sel == PERF_IDX_BASE_L1) ? nr_fetch_ports * L0_EVENT_COUNT : 0;
    endfunction

endpackage

// File: rtl/snitch_icache_perf_ctr.sv
// Single event counter with shadow copy; wraps or saturates at all-ones and flags the roll-over.
// Latency: count/clear/snapshot take effect on the next clock edge; ovf_o is combinational.
// Backpressure: none, one increment may be accepted every cycle.
module snitch_icache_perf_ctr #(
    parameter int unsigned CntWidth = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                snap_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic [CntWidth-1:0] shadow_o,
    output logic                ovf_o
);

    localparam logic [CntWidth-1:0] One = {{(CntWidth-1){1'b0}}, 1'b1};

    logic at_max;
    logic bump;

    assign at_max = &cnt_o;
    assign bump   = en_i & inc_i;
    assign ovf_o  = bump & at_max;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o    <= '0;
            shadow_o <= '0;
        end else begin
            // Snapshot takes the pre-update value, so snap+clear is an atomic read-and-reset.
            if (snap_i) begin
                shadow_o <= cnt_o;
            end
            if (clear_i) begin
                cnt_o <= '0;
            end else if (bump) begin
                if (!at_max) begin
                    cnt_o <= cnt_o + One;
                end else if (!Saturate) begin
                    cnt_o <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/snitch_icache_perf_cnt.sv
// Instruction-cache perf-counter bank (L0 per port + L1) with snapshot bank and indexed read port.
// Latency: 1 cycle read (rd_valid_o = registered rd_req_i). Optional flags: SNITCH_ICACHE_PERF_OVF_IRQ_EN.
// Backpressure: none, a read is accepted every cycle and events are never stalled.
module snitch_icache_perf_cnt
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NrFetchPorts = 2,
    parameter int unsigned CntWidth     = 32,
    parameter bit          Saturate     = 1'b0,
    parameter int unsigned NumCnt       = NrFetchPorts * L0_EVENT_COUNT + L1_EVENT_COUNT,
    parameter int unsigned IdxWidth     = $clog2(NumCnt)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  icache_l0_events_t [NrFetchPorts-1:0] l0_events_i,
    input  icache_l1_events_t                    l1_events_i,
    input  logic                                 en_i,
    input  logic                                 clear_i,
    input  logic                                 snap_i,
    input  logic                                 rd_req_i,
    input  logic [IdxWidth-1:0]                  rd_idx_i,
    input  logic                                 rd_shadow_i,
    output logic                                 rd_valid_o,
    output logic [CntWidth-1:0]                  rd_data_o,
    output logic                                 rd_err_o
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
    ,
    output logic [NumCnt-1:0]                    ovf_o,
    output logic                                 irq_o
`endif
);

    localparam int unsigned          L1Base   = perf_idx_base(NrFetchPorts, PERF_IDX_BASE_L1);
    localparam int unsigned          NumSlots = 1 << IdxWidth;
    localparam logic [IdxWidth:0]    NumCntW  = (IdxWidth + 1)'(NumCnt);

    logic [NumCnt-1:0]   inc;
    logic [NumCnt-1:0]   ovf_pulse;
    logic [CntWidth-1:0] live_cnt   [NumSlots];
    logic [CntWidth-1:0] shadow_cnt [NumSlots];
    logic                rd_oor;
    logic [CntWidth-1:0] rd_sel;

    // Struct members are MSB-first, so event k of a port sits at bit (COUNT-1-k).
    for (genvar p = 0; p < NrFetchPorts; p++) begin : g_l0_port
        for (genvar k = 0; k < L0_EVENT_COUNT; k++) begin : g_l0_evt
            assign inc[p*L0_EVENT_COUNT + k] = l0_events_i[p][L0_EVENT_COUNT-1-k];
        end
    end

    for (genvar j = 0; j < L1_EVENT_COUNT; j++) begin : g_l1_evt
        assign inc[L1Base + j] = l1_events_i[L1_EVENT_COUNT-1-j];
    end

    for (genvar i = 0; i < NumCnt; i++) begin : g_ctr
        snitch_icache_perf_ctr #(
            .CntWidth (CntWidth),
            .Saturate (Saturate)
        ) i_ctr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .inc_i    (inc[i]),
            .en_i     (en_i),
            .clear_i  (clear_i),
            .snap_i   (snap_i),
            .cnt_o    (live_cnt[i]),
            .shadow_o (shadow_cnt[i]),
            .ovf_o    (ovf_pulse[i])
        );
    end

    // Unpopulated index slots read as zero; the range check flags them as errors.
    for (genvar i = NumCnt; i < NumSlots; i++) begin : g_pad
        assign live_cnt[i]   = '0;
        assign shadow_cnt[i] = '0;
    end

    assign rd_oor = {1'b0, rd_idx_i} >= NumCntW;
    assign rd_sel = rd_shadow_i ? shadow_cnt[rd_idx_i] : live_cnt[rd_idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_req_i;
            rd_err_o   <= rd_req_i & rd_oor;
            if (rd_req_i) begin
                rd_data_o <= rd_oor ? '0 : rd_sel;
            end
        end
    end

`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= '0;
        end else if (clear_i) begin
            ovf_o <= '0;
        end else begin
            ovf_o <= ovf_o | ovf_pulse;
        end
    end

    assign irq_o = |ovf_o;
`else
    // Overflow pulses have no consumer in this build.
    logic [NumCnt-1:0] ovf_pulse_unused;
    assign ovf_pulse_unused = ovf_pulse;
`endif

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Randomised + directed bench for snitch_icache_perf_cnt against a counting model.
// Three instances: 32-bit wrap, 4-bit wrap, 4-bit saturate, all sharing one stimulus.
module tb_snitch_icache_perf_cnt;
    import snitch_icache_pkg::*;

    localparam int NCNT = 14;
    localparam int ND   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_l0_events_t [1:0] l0_events;
    icache_l1_events_t       l1_events;
    logic                    en, clear, snap, rd_req, rd_shadow;
    logic [3:0]              rd_idx;

    logic       rd_valid [ND];
    logic       rd_err   [ND];
    logic [31:0] data0;
    logic [3:0]  data1, data2;
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
    logic [NCNT-1:0] ovf [ND];
    logic            irq [ND];
`endif

    snitch_icache_perf_cnt #(.NrFetchPorts(2), .CntWidth(32), .Saturate(1'b0)) dut_w32 (
        .clk_i(clk), .rst_i(rst), .l0_events_i(l0_events), .l1_events_i(l1_events),
        .en_i(en), .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
        .rd_shadow_i(rd_shadow), .rd_valid_o(rd_valid[0]), .rd_data_o(data0), .rd_err_o(rd_err[0])
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
        , .ovf_o(ovf[0]), .irq_o(irq[0])
`endif
    );

    snitch_icache_perf_cnt #(.NrFetchPorts(2), .CntWidth(4), .Saturate(1'b0)) dut_w4 (
        .clk_i(clk), .rst_i(rst), .l0_events_i(l0_events), .l1_events_i(l1_events),
        .en_i(en), .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
        .rd_shadow_i(rd_shadow), .rd_valid_o(rd_valid[1]), .rd_data_o(data1), .rd_err_o(rd_err[1])
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
        , .ovf_o(ovf[1]), .irq_o(irq[1])
`endif
    );

    snitch_icache_perf_cnt #(.NrFetchPorts(2), .CntWidth(4), .Saturate(1'b1)) dut_s4 (
        .clk_i(clk), .rst_i(rst), .l0_events_i(l0_events), .l1_events_i(l1_events),
        .en_i(en), .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
        .rd_shadow_i(rd_shadow), .rd_valid_o(rd_valid[2]), .rd_data_o(data2), .rd_err_o(rd_err[2])
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
        , .ovf_o(ovf[2]), .irq_o(irq[2])
`endif
    );

    // Reference model: plain integer counts per instance and index.
    longint live [ND][NCNT];
    longint shd  [ND][NCNT];
    bit     mflag[ND][NCNT];
    int     wid  [ND] = '{32, 4, 4};
    bit     sat  [ND] = '{1'b0, 1'b0, 1'b1};
    longint exp_data [ND];
    bit     exp_valid, exp_err;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint cmax(input int d);
        return (longint'(1) << wid[d]) - 1;
    endfunction

    function automatic logic [63:0] obs_data(input int d);
        case (d)
            0:       return {32'b0, data0};
            1:       return {60'b0, data1};
            default: return {60'b0, data2};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            exp_data[d] = 0;
            for (int c = 0; c < NCNT; c++) begin
                live[d][c]  = 0;
                shd[d][c]   = 0;
                mflag[d][c] = 1'b0;
            end
        end
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    // Counter index space -> named struct fields.
    task automatic drive_hits(input logic [13:0] h);
        for (int p = 0; p < 2; p++) begin
            l0_events[p].l0_miss       = h[p*5+0];
            l0_events[p].l0_hit        = h[p*5+1];
            l0_events[p].l0_prefetch   = h[p*5+2];
            l0_events[p].l0_double_hit = h[p*5+3];
            l0_events[p].l0_stall      = h[p*5+4];
        end
        l1_events.l1_miss          = h[10];
        l1_events.l1_hit           = h[11];
        l1_events.l1_stall         = h[12];
        l1_events.l1_handler_stall = h[13];
    endtask

    task automatic check_outputs();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d.valid", d), {63'b0, rd_valid[d]}, {63'b0, exp_valid});
            chk($sformatf("d%0d.data", d), obs_data(d), exp_data[d]);
            chk($sformatf("d%0d.err", d), {63'b0, rd_err[d]}, {63'b0, exp_err});
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
            begin
                logic [NCNT-1:0] ef;
                ef = '0;
                for (int c = 0; c < NCNT; c++) ef[c] = mflag[d][c];
                chk($sformatf("d%0d.ovf", d), {50'b0, ovf[d]}, {50'b0, ef});
                chk($sformatf("d%0d.irq", d), {63'b0, irq[d]}, {63'b0, (ef != '0)});
            end
`endif
        end
    endtask

    task automatic cycle(input logic [13:0] h, input bit e, input bit clr, input bit s,
                         input bit r, input logic [3:0] idx, input bit sh);
        drive_hits(h);
        en = e; clear = clr; snap = s; rd_req = r; rd_idx = idx; rd_shadow = sh;
        exp_valid = r;
        exp_err   = r && (int'(idx) >= NCNT);
        for (int d = 0; d < ND; d++) begin
            if (r) exp_data[d] = (int'(idx) >= NCNT) ? 0 : (sh ? shd[d][idx] : live[d][idx]);
            for (int c = 0; c < NCNT; c++) begin
                longint old;
                old = live[d][c];
                if (s) shd[d][c] = old;
                if (clr) begin
                    live[d][c]  = 0;
                    mflag[d][c] = 1'b0;
                end else if (e && h[c]) begin
                    if (old == cmax(d)) begin
                        mflag[d][c] = 1'b1;
                        live[d][c]  = sat[d] ? old : 0;
                    end else begin
                        live[d][c] = old + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic read(input logic [3:0] idx, input bit sh);
        cycle(14'd0, 1'b0, 1'b0, 1'b0, 1'b1, idx, sh);
    endtask

    task automatic do_clear();
        cycle(14'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive_hits(14'd0);
        en = 1'b0; clear = 1'b0; snap = 1'b0; rd_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        idle();

        // Port 1 l0_hit (index 6) held for 10 cycles.
        for (int i = 0; i < 10; i++) cycle(14'd1 << 6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        read(4'd6, 1'b0);
        chk("hit10", {32'b0, data0}, 64'd10);

        // Same with enable toggling.
        do_clear();
        for (int i = 0; i < 10; i++) cycle(14'd1 << 6, (i % 2) == 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        read(4'd6, 1'b0);
        chk("hit_en_toggle", {32'b0, data0}, 64'd5);

        // l1_miss pulsed 17 times: wrap vs saturate at 4 bits.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            cycle(14'd1 << 10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            idle();
        end
        read(4'd10, 1'b0);
        chk("l1miss_w32", {32'b0, data0}, 64'd17);
        chk("l1miss_wrap4", {60'b0, data1}, 64'd1);
        chk("l1miss_sat4", {60'b0, data2}, 64'd15);
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
        chk("ovf10_wrap4", {63'b0, ovf[1][10]}, 64'd1);
        chk("ovf10_sat4", {63'b0, ovf[2][10]}, 64'd1);
        chk("irq_sat4", {63'b0, irq[2]}, 64'd1);
        do_clear();
        chk("irq_cleared", {63'b0, irq[1]}, 64'd0);
`endif

        // Atomic snapshot + clear with a same-cycle event.
        do_clear();
        for (int i = 0; i < 7; i++) cycle(14'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(14'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        read(4'd0, 1'b1);
        chk("snap_shadow0", {32'b0, data0}, 64'd7);
        read(4'd0, 1'b0);
        chk("snap_live0", {32'b0, data0}, 64'd0);

        // Out-of-range indices.
        read(4'd14, 1'b0);
        chk("oor14_err", {63'b0, rd_err[0]}, 64'd1);
        chk("oor14_data", {32'b0, data0}, 64'd0);
        read(4'd15, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(14'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset arriving while a read response is out.
        cycle(14'h3fff, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < NCNT; c++) begin
            read(4'(c), 1'b0);
            read(4'(c), 1'b1);
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/snitch_icache_perf_cnt.md
Name: snitch_icache_perf_cnt

Overview:
Performance-counter bank for the instruction cache. It accumulates the per-fetch-port L0 event vectors (icache_l0_events_t) and the shared L1 event vector (icache_l1_events_t) into parametrised-width counters. Compared with the bare event structs, it adds:
- enable and clear controls,
- an atomic snapshot bank,
- wrap or saturate counting modes,
- a registered indexed read port for the cluster peripheral/CSR layer.

Parameters:
- NrFetchPorts, 2, number of L0 event vectors (one per fetch port).
- CntWidth, 32, width of every counter (min 2, max 64).
- Saturate, 0, 1 = counters stick at all-ones; 0 = counters wrap to 0.
- NumCnt, derived = NrFetchPorts*L0_EVENT_COUNT + L1_EVENT_COUNT (= 14 at defaults).
- IdxWidth, derived = $clog2(NumCnt).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- l0_events_i  in  NrFetchPorts x $bits(icache_l0_events_t)  per-port one-cycle event pulses.
- l1_events_i  in  $bits(icache_l1_events_t)  L1 event pulses.
- en_i  in  1  global count enable.
- clear_i  in  1  zero all live counters.
- snap_i  in  1  copy all live counters into the shadow bank.
- rd_req_i  in  1  read request.
- rd_idx_i  in  IdxWidth  counter index.
- rd_shadow_i  in  1  1 = read the shadow bank, 0 = read the live bank.
- rd_valid_o  out  1  read response valid.
- rd_data_o  out  CntWidth  read data.
- rd_err_o  out  1  index out of range.

Behaviour:
- Index map:
  - index p*5+k = port p, L0 event k, where k follows struct order from the MSB: l0_miss=0, l0_hit=1, l0_prefetch=2, l0_double_hit=3, l0_stall=4.
  - index NrFetchPorts*5+j = L1 event j: l1_miss=0, l1_hit=1, l1_stall=2, l1_handler_stall=3.
- Reset: all live and shadow counters = 0; rd_valid_o = 0; rd_data_o = 0; rd_err_o = 0.
- Count rule: each cycle with en_i=1 and the event bit set, the counter increments by exactly 1. Each bit is a per-cycle level, so a bit held high N cycles counts N.
- Wrap mode: all-ones + 1 -> 0.
- Saturate mode: all-ones + 1 -> stays all-ones.
- en_i=0: counters hold; events are dropped.
- clear_i=1: all live counters = 0 next cycle. Clear has priority over a same-cycle increment (that event is lost). Shadow bank is untouched.
- snap_i=1: shadow <= live value as of the start of the cycle (the pre-increment, pre-clear value).
  - snap_i and clear_i in the same cycle: shadow captures the old values and live goes to 0. This gives atomic read-and-reset.
- Read latency is 1 cycle: rd_valid_o = registered rd_req_i.
  - rd_data_o = registered selected bank[rd_idx_i], sampled in the request cycle. It does not include that cycle's increment.
  - rd_idx_i >= NumCnt: rd_data_o = 0 and rd_err_o = 1 with rd_valid_o.
  - rd_err_o = 0 for every other response.
  - When rd_req_i = 0, rd_valid_o drops next cycle; rd_data_o holds its last value.
- Back-to-back reads are accepted every cycle; there is no backpressure.
- Reset asserted mid-operation clears everything immediately (asynchronously). A read in flight is discarded: rd_valid_o = 0.

Optional Feature:
SNITCH_ICACHE_PERF_OVF_IRQ_EN
- Defined:
  - adds port ovf_o (out, NumCnt): sticky per-counter overflow flags.
  - adds port irq_o (out, 1) = |ovf_o.
  - A flag sets on the cycle its counter increments from all-ones, in either mode.
  - clear_i clears all flags; reset value 0.
  - Overflow set and clear in the same cycle: clear wins.
- Undefined: neither port exists and there is no flag logic.

Decomposition:
- snitch_icache_pkg gains:
  - localparam L0_EVENT_COUNT = 5,
  - localparam L1_EVENT_COUNT = 4,
  - typedef icache_perf_idx_base_e: L0 base 0, L1 base = NrFetchPorts*5, as a function of NrFetchPorts.
- Event structs are reused unchanged.
- One sub-module, snitch_icache_perf_ctr: a single counter plus its shadow register, with inputs inc/en/clear/snap, parameters CntWidth/Saturate, and an overflow pulse output. The top level instantiates NumCnt of them and muxes the read.

Test Plan:
- Port-1 l0_hit held high 10 cycles with en_i=1, then read idx 6 (rd_shadow_i=0) -> rd_valid_o one cycle later, rd_data_o = 10, rd_err_o = 0.
- Same 10 cycles with en_i toggled every cycle -> idx 6 reads 5.
- CntWidth=4, Saturate=0, l1_miss (idx 10) pulsed 17 times -> reads 1.
- Same setup with Saturate=1 -> reads 15.
- With SNITCH_ICACHE_PERF_OVF_IRQ_EN: ovf_o[10] = 1 and irq_o = 1 in both runs; clear_i deasserts both.
- l0_miss port 0 at 7, then snap_i+clear_i together with a same-cycle event -> shadow idx 0 reads 7; live idx 0 reads 0.
- Read idx 14 (NumCnt=14) -> rd_valid_o=1, rd_err_o=1, rd_data_o=0.
- rst_i asserted the cycle after rd_req_i -> rd_valid_o=0 and all counters 0.
